// File: rtl/tick_stopwatch_pkg.sv
// Shared types and constants for the tick_stopwatch mm:ss stopwatch.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_NINE     = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVF   = 2'd3
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } bcd_time_t;

endpackage

// File: rtl/tick_stopwatch_if.sv
// Command, tick and display bundle between the button logic / divider and the stopwatch.
interface tick_stopwatch_if;
  import stopwatch_pkg::*;

  // start/stop/clear/lap are single-cycle pulses, sampled on the clk edge where they are
  // high; there is no back-pressure, so every pulse is acted on (or ignored) that cycle.
  logic               tick_in;
  logic               start;
  logic               stop;
  logic               clear;
  logic               lap;
  logic [DIGIT_W-1:0] sec_ones;
  logic [DIGIT_W-1:0] sec_tens;
  logic [DIGIT_W-1:0] min_ones;
  logic [DIGIT_W-1:0] min_tens;
  logic               running;
  logic               frozen;
  logic               overflow;
  state_e             fsm_state;

  modport master (
    output tick_in, start, stop, clear, lap,
    input  sec_ones, sec_tens, min_ones, min_tens, running, frozen, overflow, fsm_state
  );

  modport slave (
    input  tick_in, start, stop, clear, lap,
    output sec_ones, sec_tens, min_ones, min_tens, running, frozen, overflow, fsm_state
  );

endinterface

// File: rtl/tick_stopwatch_bcd_digit_cnt.sv
// One BCD digit counting 0..MAX; carry is combinational so digits chain within a cycle.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = BCD_NINE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (en) begin
      digit <= (digit == MAX) ? '0 : digit + 4'd1;
    end
  end

  assign carry = en & (digit == MAX);

endmodule

// File: rtl/tick_stopwatch.sv
// mm:ss stopwatch counting rising edges of a slow divided clock, with lap-freeze display.
module tick_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LIMIT   = 59
) (
  input logic             clk,
  input logic             rst_n,
  tick_stopwatch_if.slave sw
);

  localparam logic [DIGIT_W-1:0] LIM_TENS = 4'(MIN_LIMIT / 10);
  localparam logic [DIGIT_W-1:0] LIM_ONES = 4'(MIN_LIMIT % 10);
  localparam bcd_time_t LIMIT_TIME = '{LIM_TENS, LIM_ONES, SEC_TENS_MAX, BCD_NINE};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   tick_hist;
  logic                   tick_pulse;

  state_e    state_q, state_d;
  logic      frozen_q, frozen_d;
  bcd_time_t cnt;
  bcd_time_t disp_q;
  logic      at_limit;
  logic      cnt_en;
  logic      c_so, c_st, c_mo, c_mt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      tick_hist <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], sw.tick_in};
      tick_hist <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_pulse = sync_q[SYNC_STAGES-1] & ~tick_hist;

  // Saturation at the limit is done by withholding the enable, not inside the digits.
  assign at_limit = (cnt == LIMIT_TIME);
  assign cnt_en   = (state_q == ST_RUN) & tick_pulse & ~sw.clear & ~at_limit;

  bcd_digit_cnt #(.MAX(BCD_NINE)) u_sec_ones (
    .clk(clk), .rst_n(rst_n), .clr(sw.clear), .en(cnt_en),
    .digit(cnt.sec_ones), .carry(c_so)
  );

  bcd_digit_cnt #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst_n(rst_n), .clr(sw.clear), .en(c_so),
    .digit(cnt.sec_tens), .carry(c_st)
  );

  bcd_digit_cnt #(.MAX(BCD_NINE)) u_min_ones (
    .clk(clk), .rst_n(rst_n), .clr(sw.clear), .en(c_st),
    .digit(cnt.min_ones), .carry(c_mo)
  );

  bcd_digit_cnt #(.MAX(BCD_NINE)) u_min_tens (
    .clk(clk), .rst_n(rst_n), .clr(sw.clear), .en(c_mo),
    .digit(cnt.min_tens), .carry(c_mt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      frozen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      frozen_q <= frozen_d;
    end
  end

  // Command priority: clear > stop > start > lap; a lower command is dropped when a higher one is present.
  always_comb begin
    state_d  = state_q;
    frozen_d = frozen_q;
    if (sw.clear) begin
      state_d  = ST_IDLE;
      frozen_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sw.start && !sw.stop) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (sw.stop) begin
            state_d  = ST_PAUSE;
            frozen_d = 1'b0;
          end else if (tick_pulse && at_limit) begin
            state_d  = ST_OVF;
            frozen_d = 1'b0;
          end else if (sw.lap && !sw.start) begin
            frozen_d = ~frozen_q;
          end
        end
        ST_PAUSE: begin
          if (sw.start && !sw.stop) state_d = ST_RUN;
        end
        ST_OVF: begin
          state_d = ST_OVF;
        end
        default: begin
          state_d  = ST_IDLE;
          frozen_d = 1'b0;
        end
      endcase
    end
  end

  // Display holds only while frozen stays set; the freezing cycle itself captures the live count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= '0;
    end else if (sw.clear) begin
      disp_q <= '0;
    end else if (!(frozen_q && frozen_d)) begin
      disp_q <= cnt;
    end
  end

  assign sw.sec_ones  = disp_q.sec_ones;
  assign sw.sec_tens  = disp_q.sec_tens;
  assign sw.min_ones  = disp_q.min_ones;
  assign sw.min_tens  = disp_q.min_tens;
  assign sw.running   = (state_q == ST_RUN);
  assign sw.frozen    = frozen_q;
  assign sw.overflow  = (state_q == ST_OVF);
  assign sw.fsm_state = state_q;

endmodule

// File: tb/tb_tick_stopwatch.sv
// Self-checking bench for tick_stopwatch against a seconds-based behavioural model.
module tb_tick_stopwatch;
  import stopwatch_pkg::*;

  localparam int LIMIT_SECS = 59 * 60 + 59;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_OVF = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  int   m_state;
  int   m_secs;
  int   m_fz;
  bit   m_frozen;

  tick_stopwatch_if sw_if ();

  tick_stopwatch #(.SYNC_STAGES(2), .MIN_LIMIT(59)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic [15:0] to_bcd(input int v);
    int m, s;
    m = v / 60;
    s = v % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_state  = M_IDLE;
    m_secs   = 0;
    m_fz     = 0;
    m_frozen = 1'b0;
  endtask

  task automatic model_tick();
    if (m_state == M_RUN) begin
      if (m_secs == LIMIT_SECS) begin
        m_state  = M_OVF;
        m_frozen = 1'b0;
      end else begin
        m_secs++;
      end
    end
  endtask

  task automatic model_cmd(input bit s, input bit p, input bit c, input bit l);
    if (c) begin
      model_reset();
    end else if (p) begin
      if (m_state == M_RUN) begin
        m_state  = M_PAUSE;
        m_frozen = 1'b0;
      end
    end else if (s) begin
      if (m_state == M_IDLE || m_state == M_PAUSE) m_state = M_RUN;
    end else if (l) begin
      if (m_state == M_RUN) begin
        m_frozen = !m_frozen;
        if (m_frozen) m_fz = m_secs;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".disp"}, 32'({sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones}),
          32'(to_bcd(m_frozen ? m_fz : m_secs)));
    check({tag, ".running"}, 32'(sw_if.running), 32'(m_state == M_RUN));
    check({tag, ".frozen"}, 32'(sw_if.frozen), 32'(m_frozen));
    check({tag, ".overflow"}, 32'(sw_if.overflow), 32'(m_state == M_OVF));
  endtask

  // driver tasks
  task automatic do_tick(input int gap);
    @(negedge clk) sw_if.tick_in = 1'b1;
    repeat (4) @(negedge clk);
    sw_if.tick_in = 1'b0;
    repeat (gap) @(negedge clk);
    model_tick();
  endtask

  task automatic do_cmd(input bit s, input bit p, input bit c, input bit l);
    @(negedge clk);
    sw_if.start = s;
    sw_if.stop  = p;
    sw_if.clear = c;
    sw_if.lap   = l;
    @(negedge clk);
    sw_if.start = 1'b0;
    sw_if.stop  = 1'b0;
    sw_if.clear = 1'b0;
    sw_if.lap   = 1'b0;
    repeat (2) @(negedge clk);
    model_cmd(s, p, c, l);
  endtask

  initial begin
    int op;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    sw_if.tick_in = 1'b0;
    sw_if.start   = 1'b0;
    sw_if.stop    = 1'b0;
    sw_if.clear   = 1'b0;
    sw_if.lap     = 1'b0;
    model_reset();

    // reset, release with tick_in already high
    repeat (3) @(negedge clk);
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
    sw_if.tick_in = 1'b1;
    repeat (6) @(negedge clk);
    check_all("rst_rel");
    check("rst_rel.state", 32'(sw_if.fsm_state), 32'(ST_IDLE));
    sw_if.tick_in = 1'b0;
    repeat (4) @(negedge clk);

    // tick edge three cycles ahead of start is seen while still idle
    @(negedge clk) sw_if.tick_in = 1'b1;
    repeat (3) @(negedge clk);
    sw_if.start = 1'b1;
    @(negedge clk) sw_if.start = 1'b0;
    repeat (2) @(negedge clk);
    model_tick();
    model_cmd(1, 0, 0, 0);
    check_all("prestart");
    sw_if.tick_in = 1'b0;
    repeat (4) @(negedge clk);
    do_cmd(0, 0, 1, 0);

    // 61 ticks, first one timed
    do_cmd(1, 0, 0, 0);
    @(negedge clk) sw_if.tick_in = 1'b1;
    repeat (3) @(negedge clk);
    check_all("lat_before");
    @(negedge clk);
    model_tick();
    check_all("lat_after");
    sw_if.tick_in = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 60; i++) do_tick($urandom_range(6, 15));
    check_all("t61");
    check("t61.value", 32'({sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones}),
          32'h0101);

    // pause ignores ticks
    do_cmd(0, 0, 1, 0);
    do_cmd(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) do_tick($urandom_range(3, 8));
    do_cmd(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) do_tick($urandom_range(3, 8));
    check_all("paused");
    do_cmd(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) do_tick($urandom_range(3, 8));
    check_all("resume");

    // lap freeze and release
    do_cmd(0, 0, 1, 0);
    do_cmd(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) do_tick($urandom_range(3, 8));
    do_cmd(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) do_tick($urandom_range(3, 8));
    check_all("lap_on");
    do_cmd(0, 0, 0, 1);
    check_all("lap_off");

    // saturate at 59:59
    do_cmd(0, 0, 1, 0);
    do_cmd(1, 0, 0, 0);
    for (int i = 0; i < LIMIT_SECS; i++) do_tick(4);
    check_all("pre_ovf");
    do_tick(4);
    check_all("ovf");
    do_cmd(1, 0, 0, 0);
    check_all("ovf_start");
    do_cmd(0, 0, 1, 0);
    check_all("ovf_clear");
    check("ovf_clear.state", 32'(sw_if.fsm_state), 32'(ST_IDLE));

    // clear lands on the same edge as a tick pulse
    do_cmd(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) do_tick($urandom_range(3, 8));
    @(negedge clk) sw_if.tick_in = 1'b1;
    repeat (2) @(negedge clk);
    sw_if.clear = 1'b1;
    @(negedge clk);
    sw_if.clear   = 1'b0;
    sw_if.tick_in = 1'b0;
    repeat (4) @(negedge clk);
    model_cmd(0, 0, 1, 0);
    check_all("clr_tick");
    check("clr_tick.state", 32'(sw_if.fsm_state), 32'(ST_IDLE));

    // start and stop together from idle
    do_cmd(1, 1, 0, 0);
    check_all("start_stop");
    check("start_stop.state", 32'(sw_if.fsm_state), 32'(ST_IDLE));

    // randomized command/tick mix
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) do_tick($urandom_range(3, 8));
      else if (op == 5) do_cmd(1, 0, 0, 0);
      else if (op == 6) do_cmd(0, 1, 0, 0);
      else if (op == 7) do_cmd(0, 0, 0, 1);
      else do_cmd($urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
      check_all($sformatf("rnd%0d", i));
    end

    // asynchronous reset mid-run
    do_cmd(0, 0, 1, 0);
    do_cmd(1, 0, 0, 0);
    for (int i = 0; i < 30; i++) do_tick($urandom_range(3, 8));
    check_all("pre_arst");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    check("arst.state", 32'(sw_if.fsm_state), 32'(ST_IDLE));
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_all("arst_rel");

    // report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
